// File: rtl/demux_pkg.sv
// Shared types and helpers for the registered 1-to-N stream demultiplexer.
package demux_pkg;

  localparam int MAX_N     = 64;
  localparam int MAX_SEL_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } state_e;

  // Select width for n channels, never less than one bit.
  function automatic int sel_width(input int n);
    int w;
    w = 1;
    for (int i = 0; i < 8; i++) begin
      if ((1 << w) < n) w++;
    end
    return w;
  endfunction

  function automatic logic [MAX_N-1:0] onehot(input logic [MAX_SEL_W-1:0] sel, input int n);
    onehot = '0;
    if (int'(sel) < n) onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// Single output register holding one beat plus its destination channel.
module stream_reg_slice #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drain,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [SEL_W-1:0]  in_dest,
  output logic              occ,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic [SEL_W-1:0]  dest
);

  logic              occ_q, occ_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic [SEL_W-1:0]  dest_q, dest_d;

  // Load wins over drain so accept-plus-drain reloads in the same cycle.
  always_comb begin
    occ_d  = occ_q;
    data_d = data_q;
    last_d = last_q;
    dest_d = dest_q;
    if (load) begin
      occ_d  = 1'b1;
      data_d = in_data;
      last_d = in_last;
      dest_d = in_dest;
    end else if (drain) begin
      occ_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
      dest_q <= '0;
    end else begin
      occ_q  <= occ_d;
      data_q <= data_d;
      last_q <= last_d;
      dest_q <= dest_d;
    end
  end

  assign occ  = occ_q;
  assign data = data_q;
  assign last = last_q;
  assign dest = dest_q;

endmodule

// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N packet demultiplexer: destination latched on the first
// beat of a packet, out-of-range packets are swallowed and flagged.
module stream_demux_1xn
  import demux_pkg::*;
#(
  parameter  int N_OUT  = 8,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = sel_width(N_OUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic [SEL_W-1:0]  s_sel,
  output logic [N_OUT-1:0]  m_valid,
  input  logic [N_OUT-1:0]  m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              err_sel
);

  localparam logic [SEL_W:0] N_OUT_V = (SEL_W+1)'(N_OUT);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  cur_sel_q, cur_sel_d;
  logic              err_q, err_d;

  logic              occ, out_last, drain, accept, load, sel_ok;
  logic [SEL_W-1:0]  dest, load_dest;
  logic [DATA_W-1:0] out_data;

  // Only the selected channel's ready can drain, since m_valid is one-hot.
  assign drain   = |(m_valid & m_ready);
  assign s_ready = !rst && ((state_q == DROP) || !occ || drain);
  assign accept  = s_valid && s_ready;
  assign sel_ok  = {1'b0, s_sel} < N_OUT_V;

  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    err_d     = 1'b0;
    load      = 1'b0;
    load_dest = cur_sel_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (sel_ok) begin
            load      = 1'b1;
            load_dest = s_sel;
            cur_sel_d = s_sel;
            state_d   = s_last ? IDLE : PKT;
          end else begin
            err_d   = 1'b1;
            state_d = s_last ? IDLE : DROP;
          end
        end
      end
      PKT: begin
        if (accept) begin
          load = 1'b1;
          if (s_last) state_d = IDLE;
        end
      end
      DROP: begin
        if (accept && s_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_sel_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      err_q     <= err_d;
    end
  end

  stream_reg_slice #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_slice (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .drain   (drain),
    .in_data (s_data),
    .in_last (s_last),
    .in_dest (load_dest),
    .occ     (occ),
    .data    (out_data),
    .last    (out_last),
    .dest    (dest)
  );

  assign m_valid = occ ? N_OUT'(onehot(MAX_SEL_W'(dest), N_OUT)) : '0;
  assign m_data  = out_data;
  assign m_last  = out_last;
  assign err_sel = err_q;

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Bench for stream_demux_1xn: an 8-channel and a 6-channel instance, vector
// table, directed corner sequences and a queue-based random scoreboard.
module tb_stream_demux_1xn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       s_valid8, s_ready8, s_last8, m_last8, err8;
  logic [2:0] s_sel8;
  logic [7:0] s_data8, m_data8, m_valid8, m_ready8;

  logic       s_valid6, s_ready6, s_last6, m_last6, err6;
  logic [2:0] s_sel6;
  logic [7:0] s_data6, m_data6;
  logic [5:0] m_valid6, m_ready6;

  stream_demux_1xn #(.N_OUT(8), .DATA_W(8)) u8 (
    .clk(clk), .rst(rst), .s_valid(s_valid8), .s_ready(s_ready8),
    .s_data(s_data8), .s_last(s_last8), .s_sel(s_sel8),
    .m_valid(m_valid8), .m_ready(m_ready8), .m_data(m_data8),
    .m_last(m_last8), .err_sel(err8)
  );

  stream_demux_1xn #(.N_OUT(6), .DATA_W(8)) u6 (
    .clk(clk), .rst(rst), .s_valid(s_valid6), .s_ready(s_ready6),
    .s_data(s_data6), .s_last(s_last6), .s_sel(s_sel6),
    .m_valid(m_valid6), .m_ready(m_ready6), .m_data(m_data6),
    .m_last(m_last6), .err_sel(err6)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  task automatic drive8(input logic v, input logic [2:0] sel, input logic [7:0] d,
                        input logic l, input logic [7:0] mr);
    s_valid8 = v; s_sel8 = sel; s_data8 = d; s_last8 = l; m_ready8 = mr;
  endtask

  task automatic drive6(input logic v, input logic [2:0] sel, input logic [7:0] d,
                        input logic l, input logic [5:0] mr);
    s_valid6 = v; s_sel6 = sel; s_data6 = d; s_last6 = l; m_ready6 = mr;
  endtask

  // Sample between edges, then move to the next driving point.
  task automatic exp8(input string n, input logic sr, input logic [7:0] mv,
                      input logic [7:0] d, input logic l);
    #2;
    chk({n, "_sready"}, 64'(s_ready8), 64'(sr));
    chk({n, "_mvalid"}, 64'(m_valid8), 64'(mv));
    chk({n, "_err"}, 64'(err8), 64'(1'b0));
    if (mv != 8'h00) begin
      chk({n, "_mdata"}, 64'(m_data8), 64'(d));
      chk({n, "_mlast"}, 64'(m_last8), 64'(l));
    end
    @(negedge clk);
  endtask

  task automatic exp6(input string n, input logic sr, input logic [5:0] mv,
                      input logic err, input logic [7:0] d);
    #2;
    chk({n, "_sready"}, 64'(s_ready6), 64'(sr));
    chk({n, "_mvalid"}, 64'(m_valid6), 64'(mv));
    chk({n, "_err"}, 64'(err6), 64'(err));
    if (mv != 6'h00) chk({n, "_mdata"}, 64'(m_data6), 64'(d));
    @(negedge clk);
  endtask

  // Reference model for the 6-channel instance: packets and a beat queue.
  typedef struct {
    int         ch;
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t      q[$];
  bit         in_pkt    = 1'b0;
  int         cur_dest  = 0;
  bit         err_exp   = 1'b0;
  logic [5:0] prev_mv   = '0;
  logic [5:0] prev_mr   = '0;
  logic [7:0] prev_d    = '0;
  logic       prev_l    = 1'b0;

  task automatic model6();
    bit    dropping;
    bit    exp_sr;
    int    ch;
    beat_t b;
    #2;
    dropping = in_pkt && (cur_dest < 0);
    exp_sr   = dropping || (q.size() == 0) || m_ready6[q[0].ch];
    chk("r_sready", 64'(s_ready6), 64'(exp_sr));
    chk("r_err", 64'(err6), 64'(err_exp));
    chk("r_onehot_cnt", 64'($countones(m_valid6) <= 1), 64'(1'b1));
    if (prev_mv != 6'h00 && (prev_mv & prev_mr) == 6'h00) begin
      chk("r_stable_mv", 64'(m_valid6), 64'(prev_mv));
      chk("r_stable_d", 64'(m_data6), 64'(prev_d));
      chk("r_stable_l", 64'(m_last6), 64'(prev_l));
    end
    if ((m_valid6 & m_ready6) != 6'h00) begin
      if (q.size() == 0) begin
        chk("r_spurious", 64'(m_valid6), 64'(0));
      end else begin
        b  = q.pop_front();
        ch = -1;
        for (int k = 0; k < 6; k++) if (m_valid6[k]) ch = k;
        chk("r_chan", 64'(ch), 64'(b.ch));
        chk("r_data", 64'(m_data6), 64'(b.d));
        chk("r_last", 64'(m_last6), 64'(b.l));
      end
    end
    err_exp = 1'b0;
    if (s_valid6 && s_ready6) begin
      if (!in_pkt) begin
        if (int'(s_sel6) < 6) cur_dest = int'(s_sel6);
        else begin
          cur_dest = -1;
          err_exp  = 1'b1;
        end
      end
      if (cur_dest >= 0) q.push_back('{cur_dest, s_data6, s_last6});
      in_pkt = !s_last6;
    end
    prev_mv = m_valid6;
    prev_mr = m_ready6;
    prev_d  = m_data6;
    prev_l  = m_last6;
    @(negedge clk);
  endtask

  typedef struct {
    logic       sv;
    logic [2:0] sel;
    logic [7:0] d;
    logic       l;
    logic [7:0] mr;
    logic       e_sr;
    logic [7:0] e_mv;
    logic [7:0] e_d;
    logic       e_l;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Back-to-back single-beat packets sweeping every channel.
    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{1'b1, 3'(i), 8'(8'h10 + i), 1'b1, 8'hFF, 1'b1,
                 (i == 0) ? 8'h00 : 8'(8'h01 << (i - 1)), 8'(8'h10 + i - 1), 1'b1};
    end
    tbl[8] = '{1'b0, 3'd0, 8'h00, 1'b0, 8'hFF, 1'b1, 8'h80, 8'h17, 1'b1};
    tbl[9] = '{1'b0, 3'd0, 8'h00, 1'b0, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b0};

    rst = 1'b1;
    drive8(1'b0, 3'd0, 8'h00, 1'b0, 8'hFF);
    drive6(1'b0, 3'd0, 8'h00, 1'b0, 6'h3F);
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("rst_cycle_sready", 64'(s_ready8), 64'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rst_mvalid8", 64'(m_valid8), 64'(0));
    chk("rst_mdata8", 64'(m_data8), 64'(0));
    chk("rst_mlast8", 64'(m_last8), 64'(0));
    chk("rst_err8", 64'(err8), 64'(0));
    chk("rst_sready8", 64'(s_ready8), 64'(1'b1));
    chk("rst_mvalid6", 64'(m_valid6), 64'(0));
    chk("rst_err6", 64'(err6), 64'(0));
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      drive8(tbl[i].sv, tbl[i].sel, tbl[i].d, tbl[i].l, tbl[i].mr);
      exp8($sformatf("sweep%0d", i), tbl[i].e_sr, tbl[i].e_mv, tbl[i].e_d, tbl[i].e_l);
    end

    // Multi-beat packet to channel 3 with s_sel scrambled after the first beat.
    for (int b = 0; b < 5; b++) begin
      if (b < 4) drive8(1'b1, (b == 0) ? 3'd3 : 3'($urandom_range(0, 7)),
                        8'(8'h30 + b), (b == 3), 8'hFF);
      else drive8(1'b0, 3'd0, 8'h00, 1'b0, 8'hFF);
      exp8($sformatf("pkt3_%0d", b), 1'b1, (b == 0) ? 8'h00 : 8'h08,
           8'(8'h30 + b - 1), (b == 4));
    end
    exp8("pkt3_idle", 1'b1, 8'h00, 8'h00, 1'b0);

    // Reset in the middle of a packet to channel 5.
    drive8(1'b1, 3'd5, 8'h50, 1'b0, 8'hFF);
    exp8("mid_b0", 1'b1, 8'h00, 8'h00, 1'b0);
    drive8(1'b1, 3'd1, 8'h51, 1'b0, 8'hFF);
    exp8("mid_b1", 1'b1, 8'h20, 8'h50, 1'b0);
    drive8(1'b1, 3'd1, 8'h52, 1'b0, 8'hFF);
    exp8("mid_b2", 1'b1, 8'h20, 8'h51, 1'b0);
    rst = 1'b1;
    drive8(1'b0, 3'd0, 8'h00, 1'b0, 8'hFF);
    #2;
    chk("mid_rst_sready", 64'(s_ready8), 64'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    drive8(1'b1, 3'd2, 8'h60, 1'b1, 8'hFF);
    #2;
    chk("mid_post_mdata", 64'(m_data8), 64'(0));
    chk("mid_post_mlast", 64'(m_last8), 64'(0));
    exp8("mid_post", 1'b1, 8'h00, 8'h00, 1'b0);
    drive8(1'b0, 3'd0, 8'h00, 1'b0, 8'hFF);
    exp8("mid_new", 1'b1, 8'h04, 8'h60, 1'b1);
    exp8("mid_idle", 1'b1, 8'h00, 8'h00, 1'b0);

    // Backpressure on channel 6 while all other channels are ready.
    drive8(1'b1, 3'd6, 8'hA0, 1'b0, 8'hBF);
    exp8("bp_b0", 1'b1, 8'h00, 8'h00, 1'b0);
    for (int c = 0; c < 5; c++) begin
      drive8(1'b1, 3'd0, 8'hA1, 1'b0, 8'hBF);
      exp8($sformatf("bp_stall%0d", c), 1'b0, 8'h40, 8'hA0, 1'b0);
    end
    drive8(1'b1, 3'd0, 8'hA1, 1'b0, 8'hFF);
    exp8("bp_resume", 1'b1, 8'h40, 8'hA0, 1'b0);
    drive8(1'b1, 3'd0, 8'hA2, 1'b1, 8'hFF);
    exp8("bp_b1", 1'b1, 8'h40, 8'hA1, 1'b0);
    drive8(1'b0, 3'd0, 8'h00, 1'b0, 8'hFF);
    exp8("bp_b2", 1'b1, 8'h40, 8'hA2, 1'b1);
    exp8("bp_idle", 1'b1, 8'h00, 8'h00, 1'b0);

    // Channel switch while the previous last beat is stalled.
    drive8(1'b1, 3'd2, 8'hC0, 1'b1, 8'hFB);
    exp8("sw_c2", 1'b1, 8'h00, 8'h00, 1'b0);
    drive8(1'b1, 3'd4, 8'hC1, 1'b1, 8'hFB);
    exp8("sw_hold0", 1'b0, 8'h04, 8'hC0, 1'b1);
    exp8("sw_hold1", 1'b0, 8'h04, 8'hC0, 1'b1);
    drive8(1'b1, 3'd4, 8'hC1, 1'b1, 8'hFF);
    exp8("sw_release", 1'b1, 8'h04, 8'hC0, 1'b1);
    drive8(1'b0, 3'd0, 8'h00, 1'b0, 8'hFF);
    exp8("sw_c4", 1'b1, 8'h10, 8'hC1, 1'b1);
    exp8("sw_idle", 1'b1, 8'h00, 8'h00, 1'b0);

    // Out-of-range packet on the 6-channel instance, then a valid one.
    drive6(1'b1, 3'd7, 8'hD0, 1'b0, 6'h3F);
    exp6("drop_b0", 1'b1, 6'h00, 1'b0, 8'h00);
    drive6(1'b1, 3'd1, 8'hD1, 1'b0, 6'h3F);
    exp6("drop_b1", 1'b1, 6'h00, 1'b1, 8'h00);
    drive6(1'b1, 3'd0, 8'hD2, 1'b1, 6'h3F);
    exp6("drop_b2", 1'b1, 6'h00, 1'b0, 8'h00);
    drive6(1'b1, 3'd1, 8'hE0, 1'b1, 6'h3F);
    exp6("drop_next", 1'b1, 6'h00, 1'b0, 8'h00);
    drive6(1'b0, 3'd0, 8'h00, 1'b0, 6'h3F);
    exp6("drop_ch1", 1'b1, 6'h02, 1'b0, 8'hE0);
    exp6("drop_idle", 1'b1, 6'h00, 1'b0, 8'h00);

    // Random traffic against the packet-level model.
    for (int c = 0; c < 400; c++) begin
      drive6($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
             $urandom_range(0, 2) == 0, 6'($urandom));
      model6();
    end
    drive6(1'b0, 3'd0, 8'h00, 1'b0, 6'h3F);
    for (int c = 0; c < 4; c++) model6();
    chk("r_drained", 64'(q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
